// File: rtl/pipe_front_ctrl.sv
// Front half of the 5-stage MIPS pipeline: PC, IF/ID and ID/EX registers,
// D-stage operand forwarding and next-PC resolution with one delay slot.
module pipe_front_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       ForwardrsD,
  input  logic [1:0]       ForwardrtD,
  input  logic [31:0]      ALUOutM,
  input  logic [31:0]      PC8M,
  input  logic [31:0]      InsF,
  input  logic [31:0]      rd1,
  input  logic [31:0]      rd2,
  output logic [31:0]      PCF,
  output logic [31:0]      InsD,
  output logic [31:0]      PC8D,
  output logic [31:0]      InsE,
  output logic [31:0]      RD1E,
  output logic [31:0]      RD2E,
  output logic [31:0]      PC8E,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [31:0] fsrs;
  logic [31:0] fsrt;
  logic [31:0] pcD;
  logic [31:0] brOffset;
  logic [31:0] npc;
  logic [5:0]  opD;
  logic [5:0]  fnD;

  assign opD = InsD[31:26];
  assign fnD = InsD[5:0];

  // D-stage operand forwarding; select value 3 falls back to the GRF read
  always_comb begin
    fsrs = rd1;
    fsrt = rd2;
    case (ForwardrsD)
      2'd1:    fsrs = ALUOutM;
      2'd2:    fsrs = PC8M;
      default: fsrs = rd1;
    endcase
    case (ForwardrtD)
      2'd1:    fsrt = ALUOutM;
      2'd2:    fsrt = PC8M;
      default: fsrt = rd2;
    endcase
  end

  assign pcD      = PC8D - 32'd8;
  assign brOffset = {{14{InsD[15]}}, InsD[15:0], 2'b00};

  // Next-PC: branch/jump resolved in D, sequential fetch otherwise
  always_comb begin
    npc = PCF + 32'd4;
    if (opD == OP_BEQ) begin
      if (fsrs == fsrt) npc = pcD + 32'd4 + brOffset;
    end else if (opD == OP_J || opD == OP_JAL) begin
      npc = {pcD[31:28], InsD[25:0], 2'b00};
    end else if (opD == OP_RTYPE && fnD == FN_JR) begin
      npc = fsrs;
    end
  end

  // Stall holds F/D and feeds a bubble to E; the delay slot is never squashed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF       <= RESET_PC;
      InsD      <= '0;
      PC8D      <= RESET_PC + 32'd8;
      InsE      <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      PC8E      <= RESET_PC + 32'd8;
      stall_cnt <= '0;
    end else if (stall) begin
      InsE <= '0;
      RD1E <= '0;
      RD2E <= '0;
      PC8E <= PC8D;
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      PCF  <= npc;
      InsD <= InsF;
      PC8D <= PCF + 32'd8;
      InsE <= InsD;
      RD1E <= fsrs;
      RD2E <= fsrt;
      PC8E <= PC8D;
    end
  end

endmodule
